// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter with ready/load handshake.
// One bit is consumed per clk edge with shift_en=1; done pulses after the last bit.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    input  logic             shift_en,
    output logic             ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    // State register; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: accept in IDLE, shift toward the output end in SHIFT.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = p_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic out_bit;
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    assign ready   = (state_q == IDLE);
    assign s_valid = (state_q == SHIFT);
    assign s_out   = s_valid & out_bit;
    assign done    = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances
// share all inputs and are checked against hand-computed sequences.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] p_in;
    logic       shift_en;
    logic       rdy_m, so_m, sv_m, dn_m;
    logic       rdy_l, so_l, sv_l, dn_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load(load), .p_in(p_in),
        .shift_en(shift_en), .ready(rdy_m), .s_out(so_m),
        .s_valid(sv_m), .done(dn_m)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load(load), .p_in(p_in),
        .shift_en(shift_en), .ready(rdy_l), .s_out(so_l),
        .s_valid(sv_l), .done(dn_l)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] din;
        logic       en;
        logic       e_rdy;
        logic       e_som;
        logic       e_sol;
        logic       e_sv;
        logic       e_dn;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic som,
                           input logic sol, input logic sv, input logic dn);
        chk({tag, " ready_m"}, rdy_m, rdy);
        chk({tag, " ready_l"}, rdy_l, rdy);
        chk({tag, " s_out_m"}, so_m, som);
        chk({tag, " s_out_l"}, so_l, sol);
        chk({tag, " s_valid_m"}, sv_m, sv);
        chk({tag, " s_valid_l"}, sv_l, sv);
        chk({tag, " done_m"}, dn_m, dn);
        chk({tag, " done_l"}, dn_l, dn);
    endtask

    function automatic vec_t mk(logic rst, logic ld, logic [7:0] din, logic en,
                                logic r, logic sm, logic sl, logic sv, logic d);
        vec_t v;
        v.rst = rst; v.ld = ld; v.din = din; v.en = en;
        v.e_rdy = r; v.e_som = sm; v.e_sol = sl; v.e_sv = sv; v.e_dn = d;
        return v;
    endfunction

    // Load w, keep p_in scrambled afterwards, shift each bit for per cycles.
    // If busy_at >= 0, pulse load with 8'hFF while bit busy_at is shown.
    task automatic run_word(input logic [7:0] w, input int per, input int busy_at);
        logic [7:0] wv;
        wv = w;
        load = 1'b1; p_in = w; shift_en = 1'b0;
        step();
        load = 1'b0; p_in = ~w;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < per; j++) begin
                chk_all($sformatf("w%02h b%0d c%0d", w, k, j),
                        1'b0, wv[7-k], wv[k], 1'b1, 1'b0);
                load = (k == busy_at && j == 0);
                p_in = load ? 8'hFF : ~w;
                shift_en = (j == per - 1);
                step();
            end
        end
        load = 1'b0; shift_en = 1'b0;
        chk_all($sformatf("w%02h done", w), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all($sformatf("w%02h post", w), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        int dcyc[$];

        reset = 1'b0; load = 1'b0; p_in = 8'h00; shift_en = 1'b0;

        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; load = tbl[i].ld;
            p_in = tbl[i].din; shift_en = tbl[i].en;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_som,
                    tbl[i].e_sol, tbl[i].e_sv, tbl[i].e_dn);
        end
        reset = 1'b0; load = 1'b0; shift_en = 1'b0;

        run_word(8'h01, 1, -1);
        run_word(8'hF0, 3, -1);
        run_word(8'h3C, 1, 3);

        // Reset mid-transfer after bit 5: word dropped, no done pulse.
        w = 8'h3C;
        load = 1'b1; p_in = w; shift_en = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_all($sformatf("rst b%0d", k), 1'b0, w[7-k], w[k], 1'b1, 1'b0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_all($sformatf("rst idle%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Back-to-back: 8'h81 then 8'h7E loaded during the done cycle.
        load = 1'b1; p_in = 8'h81; shift_en = 1'b1;
        step();
        load = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c <= 8) begin
                w = 8'h81;
                chk_all($sformatf("b2b c%0d", c), 1'b0, w[8-c], w[c-1], 1'b1, 1'b0);
            end else if (c == 9 || c == 18) begin
                chk_all($sformatf("b2b c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end else if (c <= 17) begin
                w = 8'h7E;
                chk_all($sformatf("b2b c%0d", c), 1'b0, w[17-c], w[c-10], 1'b1, 1'b0);
            end else begin
                chk_all($sformatf("b2b c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (dn_m) dcyc.push_back(c);
            load = (c == 9);
            p_in = (c == 9) ? 8'h7E : 8'h00;
            step();
        end
        load = 1'b0; shift_en = 1'b0;

        checks++;
        if (dcyc.size() != 2) begin
            errors++;
            $display("FAIL b2b done count: got %0d expected 2", dcyc.size());
        end else begin
            checks++;
            if (dcyc[1] - dcyc[0] != 9) begin
                errors++;
                $display("FAIL b2b done spacing: got %0d expected 9", dcyc[1] - dcyc[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter for the team's serial link. It is the sending end for the 8-bit SIPO shift-register receivers.
- Accepts a parallel word through a ready/load handshake and shifts it out one bit per enabled clock.
- Each serialized bit is qualified with a valid strobe.
- Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, number of bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to accept p_in; honoured only while ready=1.
- p_in  input  WIDTH  parallel word to transmit; sampled on the accepting edge only.
- shift_en  input  1  bit-rate tick; one bit is consumed per clk edge with shift_en=1 in SHIFT.
- ready  output  1  block is idle and can accept a load.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out carries a live data bit.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: it acts only on a clk rising edge with reset=1.
- Reset values:
  - state=IDLE, shreg=0, cnt=0.
  - ready=1, s_out=0, s_valid=0, done=0.
- Reset has priority over every other input, including mid-transfer. A word in flight is discarded, and no done pulse is produced.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- State machine, two states:
  - IDLE:
    - ready=1, s_valid=0, s_out=0.
    - load=1 at an edge: shreg<=p_in, cnt<=0, go to SHIFT. shift_en is ignored in IDLE.
  - SHIFT:
    - ready=0, s_valid=1.
    - s_out = shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
    - Edge with shift_en=1 and cnt<WIDTH-1: shift shreg one place toward the output end, fill with 0, cnt<=cnt+1.
    - Edge with shift_en=1 and cnt==WIDTH-1: last bit consumed. Go to IDLE, done<=1, shreg<=0, cnt<=0.
    - Edge with shift_en=0: hold all state; s_out holds its value.
- Latency:
  - The first bit appears on s_out in the cycle immediately after the accepting edge.
  - With shift_en held at 1, bit k is on s_out during cycle k+1 after acceptance (k=0..WIDTH-1).
  - done=1 and ready=1 appear in cycle WIDTH+1.
- done:
  - High for exactly one cycle, coincident with the first IDLE cycle.
  - Cleared on the next edge regardless of load.
- Load while busy (state SHIFT): ignored. shreg and cnt are unaffected and no error is flagged.
- Back-to-back: load=1 during the done cycle is accepted (ready=1). The next word's first bit appears in the following cycle, so there is no dead cycle beyond the done cycle.
- p_in changes after acceptance have no effect on the word in flight.
- cnt width: $clog2(WIDTH). cnt never exceeds WIDTH-1.

Test Plan:
- Reset, then hold all inputs at 0 for 3 cycles -> ready=1, s_out=0, s_valid=0, done=0 throughout. Assert reset for one edge mid-idle -> same values.
- WIDTH=8, MSB_FIRST=1, shift_en=1 constantly, load p_in=8'hA5 -> over the next 8 cycles s_out=1,0,1,0,0,1,0,1 with s_valid=1 and ready=0. Cycle 9: done=1, ready=1, s_valid=0. Cycle 10: done=0.
- Same word with MSB_FIRST=0 -> s_out=1,0,1,0,0,1,0,1 (bit0 first, and 8'hA5 is palindromic). Repeat with 8'h01 -> s_out=1,0,0,0,0,0,0,0.
- p_in=8'hF0, shift_en asserted every third cycle -> each bit is held for exactly 3 cycles. Sequence 1,1,1,1,0,0,0,0. done occurs one cycle after the 8th enabled edge.
- Load 8'h3C, then pulse load with p_in=8'hFF at bit 3 -> the second load is ignored and the full 3C sequence completes. Reset asserted after bit 5 -> next cycle: ready=1, s_valid=0, s_out=0, and no done pulse.
- Load 8'h81, then load 8'h7E in the done cycle, shift_en=1 -> s_out=1,0,0,0,0,0,0,1, then one cycle with s_valid=0, then 0,1,1,1,1,1,1,0. There are two done pulses, exactly 9 cycles apart.
